// File: rtl/benes_pkg.sv
// Shared constants and types for the 32-port Benes network and its configuration loader.
package benes_pkg;

    localparam int SIZE       = 32;
    localparam int LAYER_NUM  = $clog2(SIZE);
    localparam int STAGE_NUM  = 2 * LAYER_NUM - 1;
    localparam int SWITCH_NUM = SIZE / 2;
    localparam int STAGE_W    = $clog2(STAGE_NUM);

    typedef logic [SWITCH_NUM-1:0] sw_word_t;

    typedef enum logic [1:0] {LOAD, FULL, COMMIT} ld_state_t;

endpackage

// File: rtl/benes_cfg_loader.sv
// Shadow-bank loader that commits a complete Benes switch configuration atomically on swap_en.
// Optional macro CFG_PARITY_EN adds an even-parity check on every accepted word.
module benes_cfg_loader
    import benes_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [SWITCH_NUM-1:0]   cfg_word,
    input  logic                    cfg_last,
`ifdef CFG_PARITY_EN
    input  logic                    cfg_parity,
`endif
    input  logic                    swap_en,
    output logic [SWITCH_NUM-1:0]   switch_set [0:STAGE_NUM-1],
    output logic                    cfg_done,
    output logic                    err_seq,
    output logic [7:0]              commit_cnt,
    output logic [STAGE_W-1:0]      load_stage
);

    ld_state_t state;
    sw_word_t  shadow [0:STAGE_NUM-1];

    logic accept;
    logic at_last;
    logic parity_ok;
    logic frame_err;

    assign accept  = cfg_valid && cfg_ready;
    assign at_last = (load_stage == STAGE_W'(STAGE_NUM - 1));

`ifdef CFG_PARITY_EN
    assign parity_ok = ((^cfg_word) == cfg_parity);
`else
    assign parity_ok = 1'b1;
`endif

    // cfg_last must coincide exactly with the final stage; either mismatch is a framing error.
    assign frame_err = !parity_ok || (cfg_last != at_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            load_stage <= '0;
            cfg_ready  <= 1'b0;
            cfg_done   <= 1'b0;
            err_seq    <= 1'b0;
            commit_cnt <= '0;
            for (int s = 0; s < STAGE_NUM; s++) begin
                shadow[s]     <= '0;
                switch_set[s] <= '0;
            end
        end else begin
            cfg_done <= 1'b0;
            err_seq  <= 1'b0;
            unique case (state)
                LOAD: begin
                    cfg_ready <= 1'b1;
                    if (accept) begin
                        if (frame_err) begin
                            // Restart from stage 0; partial shadow contents are never committed.
                            err_seq    <= 1'b1;
                            load_stage <= '0;
                        end else begin
                            shadow[load_stage] <= cfg_word;
                            if (at_last) begin
                                state     <= FULL;
                                cfg_ready <= 1'b0;
                            end else begin
                                load_stage <= load_stage + STAGE_W'(1);
                            end
                        end
                    end
                end
                FULL: begin
                    cfg_ready <= 1'b0;
                    if (swap_en) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    for (int s = 0; s < STAGE_NUM; s++) begin
                        switch_set[s] <= shadow[s];
                    end
                    commit_cnt <= commit_cnt + 8'd1;
                    cfg_done   <= 1'b1;
                    load_stage <= '0;
                    cfg_ready  <= 1'b1;
                    state      <= LOAD;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule
